// File: rtl/mac_pkg.sv
// Shared definitions for the MAC scheduler and the mac datapath:
// scheduler FSM states and the operand mode encoding.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    CONF   = 3'd2,
    SETTLE = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam logic MODE_INT = 1'b0;
  localparam logic MODE_FP  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping, returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NREQ;
      idx = req[pos] ? IW'(pos) : idx;
      any = any | req[pos];
    end
    gnt = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one mac datapath between NREQ requesters:
// arbitrate, configure, stream operand pairs, collect the result.
module mac_sched
  import mac_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int CFG_WAIT  = 2,
  parameter int DRAIN_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_mode,
  input  logic [NREQ*8-1:0] req_len,
  output logic [NREQ-1:0]   grant,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DW-1:0]     op_a,
  input  logic [DW-1:0]     op_b,
  output logic              mac_config_en,
  output logic              mac_float_int,
  output logic [7:0]        mac_data_num,
  output logic [DW-1:0]     mac_in_a,
  output logic [DW-1:0]     mac_in_b,
  output logic              mac_valid,
  input  logic              mac_out_valid,
  input  logic [DW-1:0]     mac_out,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     res,
  output logic              res_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] CFG_LAST   = 8'(CFG_WAIT - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [NREQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic              op_ready_q, op_ready_d;
  logic              mac_config_en_q, mac_config_en_d;
  logic              mac_float_int_q, mac_float_int_d;
  logic [7:0]        mac_data_num_q, mac_data_num_d;
  logic [DW-1:0]     mac_in_a_q, mac_in_a_d, mac_in_b_q, mac_in_b_d;
  logic              mac_valid_q, mac_valid_d;
  logic [DW-1:0]     res_q, res_d;
  logic              res_err_q, res_err_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [7:0]        arb_len;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign arb_len = req_len[{arb_idx, 3'b000} +: 8];

  // cnt_q is reused as settle, beat and drain counter; it is zeroed at each phase change.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    grant_d         = grant_q;
    mac_float_int_d = mac_float_int_q;
    mac_data_num_d  = mac_data_num_q;
    mac_in_a_d      = mac_in_a_q;
    mac_in_b_d      = mac_in_b_q;
    mac_valid_d     = 1'b0;
    res_d           = res_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) state_d = ARB;
        else            state_d = IDLE;
      end
      ARB: begin
        if (arb_any) begin
          idx_d           = arb_idx;
          grant_d         = arb_gnt;
          mac_float_int_d = req_mode[arb_idx];
          mac_data_num_d  = arb_len;
          cnt_d           = 8'd0;
          if (arb_len == 8'd0) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = CONF;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONF: begin
        cnt_d = 8'd0;
        if (CFG_WAIT == 0) state_d = STREAM;
        else               state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CFG_LAST) begin
          cnt_d   = 8'd0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STREAM: begin
        if (op_valid && op_ready_q) begin
          mac_in_a_d  = op_a;
          mac_in_b_d  = op_b;
          mac_valid_d = 1'b1;
          if (cnt_q + 8'd1 == mac_data_num_q) begin
            cnt_d   = 8'd0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          // A hole after the first beat resets the MAC's running sum.
          err_d = err_q | (cnt_q != 8'd0);
        end
      end
      DRAIN: begin
        if (mac_out_valid) begin
          res_d   = mac_out;
          state_d = DONE;
        end else if (cnt_q == DRAIN_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    op_ready_d      = (state_d == STREAM);
    mac_config_en_d = (state_d == CONF);
    done_d          = (state_d == DONE) ? grant_d : '0;
    res_err_d       = (state_d == DONE) ? err_d : 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      idx_q           <= '0;
      cnt_q           <= 8'd0;
      err_q           <= 1'b0;
      grant_q         <= '0;
      op_ready_q      <= 1'b0;
      mac_config_en_q <= 1'b0;
      mac_float_int_q <= MODE_INT;
      mac_data_num_q  <= 8'd0;
      mac_in_a_q      <= '0;
      mac_in_b_q      <= '0;
      mac_valid_q     <= 1'b0;
      done_q          <= '0;
      res_q           <= '0;
      res_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      grant_q         <= grant_d;
      op_ready_q      <= op_ready_d;
      mac_config_en_q <= mac_config_en_d;
      mac_float_int_q <= mac_float_int_d;
      mac_data_num_q  <= mac_data_num_d;
      mac_in_a_q      <= mac_in_a_d;
      mac_in_b_q      <= mac_in_b_d;
      mac_valid_q     <= mac_valid_d;
      done_q          <= done_d;
      res_q           <= res_d;
      res_err_q       <= res_err_d;
    end
  end

  assign grant         = grant_q;
  assign op_ready      = op_ready_q;
  assign mac_config_en = mac_config_en_q;
  assign mac_float_int = mac_float_int_q;
  assign mac_data_num  = mac_data_num_q;
  assign mac_in_a      = mac_in_a_q;
  assign mac_in_b      = mac_in_b_q;
  assign mac_valid     = mac_valid_q;
  assign done          = done_q;
  assign res           = res_q;
  assign res_err       = res_err_q;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a small accumulating MAC model that
// clears its sum when valid drops mid-job.
module tb_mac_sched;
  import mac_pkg::*;

  localparam int NREQ = 4, DW = 16, CFG_WAIT = 2, DRAIN_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0, req_mode = '0;
  logic [NREQ*8-1:0] req_len = '0;
  logic [NREQ-1:0]   grant, done;
  logic              op_valid = 1'b0, op_ready;
  logic [DW-1:0]     op_a = '0, op_b = '0;
  logic              mac_config_en, mac_float_int, mac_valid;
  logic [7:0]        mac_data_num;
  logic [DW-1:0]     mac_in_a, mac_in_b, res;
  logic              mac_out_valid, res_err;
  logic [DW-1:0]     mac_out;

  int n_total = 0, n_bad = 0;

  mac_sched #(.NREQ(NREQ), .DW(DW), .CFG_WAIT(CFG_WAIT), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_mode(req_mode), .req_len(req_len),
    .grant(grant), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_config_en(mac_config_en), .mac_float_int(mac_float_int), .mac_data_num(mac_data_num),
    .mac_in_a(mac_in_a), .mac_in_b(mac_in_b), .mac_valid(mac_valid),
    .mac_out_valid(mac_out_valid), .mac_out(mac_out), .done(done), .res(res), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // MAC model: result one cycle after the last valid beat; sum cleared on a valid hole.
  logic          mac_mute = 1'b0;
  logic [DW-1:0] m_acc;
  logic [7:0]    m_cnt, m_num;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= '0; m_cnt <= 8'd0; m_num <= 8'd0; mac_out <= '0; mac_out_valid <= 1'b0;
    end else begin
      mac_out_valid <= 1'b0;
      if (mac_config_en) begin
        m_acc <= '0; m_cnt <= 8'd0; m_num <= mac_data_num;
      end else if (mac_valid) begin
        m_acc <= m_acc + mac_in_a * mac_in_b;
        m_cnt <= m_cnt + 8'd1;
        if (m_cnt + 8'd1 == m_num && !mac_mute) begin
          mac_out       <= m_acc + mac_in_a * mac_in_b;
          mac_out_valid <= 1'b1;
        end
      end else if (m_cnt != 8'd0) begin
        m_acc <= '0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0]   pa [8];
  logic [DW-1:0]   pb [8];
  logic [NREQ-1:0] j_done;
  logic [DW-1:0]   j_res;
  logic            j_err;
  int j_gcyc, j_ccyc, j_rcyc, j_ncfg, j_rdy, j_lat;

  // One job from an IDLE start: cycle n counts negedges after the request is raised.
  task automatic run_job(input logic [NREQ-1:0] mask, input logic mode, input logic [7:0] len,
                         input int gap_after);
    int sent, last;
    bit gapped;
    j_done = '0; j_res = '0; j_err = 1'b0;
    j_gcyc = -1; j_ccyc = -1; j_rcyc = -1; j_ncfg = 0; j_rdy = 0; j_lat = -1;
    sent = 0; last = 0; gapped = 1'b0;
    @(negedge clk);
    req_mode = {NREQ{mode}}; req_len = {NREQ{len}}; req_valid = mask;
    for (int n = 1; n <= 120 && j_done == '0; n++) begin
      @(negedge clk);
      if (n == 2) req_valid = '0;
      if (grant != '0 && j_gcyc < 0) j_gcyc = n;
      if (mac_config_en) begin j_ncfg++; if (j_ccyc < 0) j_ccyc = n; end
      if (op_ready) begin j_rdy++; if (j_rcyc < 0) j_rcyc = n; end
      if (done != '0) begin j_done = done; j_res = res; j_err = res_err; j_lat = n - last; end
      op_valid = 1'b0;
      if (op_ready && sent < int'(len)) begin
        if (sent == gap_after && !gapped) begin
          gapped = 1'b1;
        end else begin
          op_a = pa[sent]; op_b = pb[sent]; op_valid = 1'b1; sent++;
          if (sent == int'(len)) last = n;
        end
      end
    end
    req_valid = '0; op_valid = 1'b0;
  endtask

  logic [NREQ-1:0] rr_seen [5];
  int ndone;

  initial begin
    for (int i = 0; i < 5; i++) rr_seen[i] = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ctl", {grant, op_ready, mac_config_en, mac_float_int, mac_data_num,
                          mac_valid, done, res_err}, 64'd0);
    check_val("rst_data", {mac_in_a, mac_in_b, res}, 64'd0);
    rst_n = 1'b1;

    // int job: 2*3 + 4*5 + 1*1
    pa[0] = 16'd2; pb[0] = 16'd3; pa[1] = 16'd4; pb[1] = 16'd5; pa[2] = 16'd1; pb[2] = 16'd1;
    run_job(4'b0001, MODE_INT, 8'd3, -1);
    check_val("int_grant_cyc", 64'(j_gcyc), 64'd2);
    check_val("int_cfg_cyc", 64'(j_ccyc), 64'd2);
    check_val("int_cfg_pulses", 64'(j_ncfg), 64'd1);
    check_val("int_ready_cyc", 64'(j_rcyc), 64'(3 + CFG_WAIT));
    check_val("int_ready_len", 64'(j_rdy), 64'd3);
    check_val("int_done", 64'(j_done), 64'b0001);
    check_val("int_res", 64'(j_res), 64'd27);
    check_val("int_err", 64'(j_err), 64'd0);
    check_val("int_lat", 64'(j_lat), 64'd3);
    check_val("int_num_held", {mac_float_int, mac_data_num}, {1'b0, 8'd3});

    // gap after beat 2: MAC restarts, so only 3*3 + 4*4 survives
    for (int i = 0; i < 4; i++) begin pa[i] = 16'(i + 1); pb[i] = 16'(i + 1); end
    run_job(4'b0010, MODE_INT, 8'd4, 2);
    check_val("gap_done", 64'(j_done), 64'b0010);
    check_val("gap_err", 64'(j_err), 64'd1);
    check_val("gap_res", 64'(j_res), 64'd25);
    check_val("gap_ready_len", 64'(j_rdy), 64'd5);

    run_job(4'b0100, MODE_INT, 8'd0, -1);
    check_val("zero_cfg_pulses", 64'(j_ncfg), 64'd0);
    check_val("zero_done", 64'(j_done), 64'b0100);
    check_val("zero_res", 64'(j_res), 64'd0);
    check_val("zero_err", 64'(j_err), 64'd1);

    mac_mute = 1'b1;
    pa[0] = 16'd7; pb[0] = 16'd2; pa[1] = 16'd3; pb[1] = 16'd4;
    run_job(4'b1000, MODE_FP, 8'd2, -1);
    mac_mute = 1'b0;
    check_val("drain_done", 64'(j_done), 64'b1000);
    check_val("drain_lat", 64'(j_lat), 64'(DRAIN_MAX + 1));
    check_val("drain_res", 64'(j_res), 64'd0);
    check_val("drain_err", 64'(j_err), 64'd1);
    check_val("drain_mode_held", {mac_float_int, mac_data_num}, {1'b1, 8'd2});

    // pointer is back at 0: all requesting gives 0,1,2,3,0
    @(negedge clk);
    req_len = '0; req_valid = '1;
    ndone = 0;
    for (int n = 0; n < 60 && ndone < 5; n++) begin
      @(negedge clk);
      if (done != '0) begin rr_seen[ndone] = done; ndone++; end
    end
    req_valid = '0;
    check_val("rr_0", 64'(rr_seen[0]), 64'b0001);
    check_val("rr_1", 64'(rr_seen[1]), 64'b0010);
    check_val("rr_2", 64'(rr_seen[2]), 64'b0100);
    check_val("rr_3", 64'(rr_seen[3]), 64'b1000);
    check_val("rr_4", 64'(rr_seen[4]), 64'b0001);
    run_job(4'b0010, MODE_INT, 8'd0, -1);
    check_val("rr_pick1", 64'(j_done), 64'b0010);
    run_job(4'b0011, MODE_INT, 8'd0, -1);
    check_val("rr_wrap", 64'(j_done), 64'b0001);

    // async reset in the middle of streaming
    @(negedge clk);
    req_mode = '1; req_len = {NREQ{8'd4}}; req_valid = 4'b0010;
    for (int n = 0; n < 20 && !op_ready; n++) begin
      @(negedge clk);
      if (grant != '0) req_valid = '0;
    end
    op_a = 16'd5; op_b = 16'd6; op_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_grant", 64'(grant), 64'b0010);
    check_val("mid_valid", {mac_valid, mac_float_int}, 64'b11);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_ctl", {grant, op_ready, mac_config_en, mac_float_int, mac_data_num,
                            mac_valid, done, res_err}, 64'd0);
    check_val("async_data", {mac_in_a, mac_in_b, res}, 64'd0);
    op_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(4'b1111, MODE_INT, 8'd0, -1);
    check_val("post_rst_ptr", 64'(j_done), 64'b0001);
    check_val("post_rst_grant_cyc", 64'(j_gcyc), 64'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
